// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: sequential RV32M multiply/divide unit; define MULDIV_ZERO_SKIP_EN to short-cut zero operands
module ex_muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [31:0] hi, lo, m;
  logic        is_mul, sa, sb, dz, ov, zs, special, accept, ge;
  logic [31:0] ma, mb, special_res, sh_low, div_raw, fixed;
  logic [32:0] sum;
  logic [63:0] prod;
  always_comb begin
    is_mul = ~op[2];
    sa = a[31] & (is_mul ? op[1:0] != 2'b11 : ~op[0]);
    sb = b[31] & (is_mul ? ~op[1] : ~op[0]);
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    dz = op[2] & (b == 32'd0);
    ov = op[2] & ~op[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
`ifdef MULDIV_ZERO_SKIP_EN
    zs = op[2] ? (a == 32'd0) & (b != 32'd0) : (a == 32'd0) | (b == 32'd0);
`else
    zs = 1'b0;
`endif
    special = dz | ov | zs;
    special_res = dz ? (op[1] ? a : 32'hFFFF_FFFF) : ov ? (op[1] ? 32'd0 : 32'h8000_0000) : 32'd0;
    accept = start & ~flush & (state == IDLE);
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
    sh_low = {hi[30:0], lo[31]};
    ge = {hi, lo[31]} >= {1'b0, m};
    // high product word needs the borrow from the low word, so negate all 64 bits
    prod = neg_q ? -{hi, lo} : {hi, lo};
    div_raw = op_q[1] ? hi : lo;
    fixed = ~op_q[2] ? (op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]) : (neg_q ? -div_raw : div_raw);
  end
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = start ? (special ? DONE : CALC) : IDLE;
        CALC:    state_nx = cnt == 5'd31 ? FIX : CALC;
        FIX:     state_nx = DONE;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 5'd0;
      op_q <= 3'd0;
      neg_q <= 1'b0;
      hi <= 32'd0;
      lo <= 32'd0;
      m <= 32'd0;
      result <= 32'd0;
    end else if (accept) begin
      op_q <= op;
      neg_q <= (op[2] & op[1]) ? sa : sa ^ sb;
      hi <= 32'd0;
      lo <= op[2] ? ma : mb;
      m <= op[2] ? mb : ma;
      cnt <= 5'd0;
      if (special) result <= special_res;
    end else if (state == CALC && !flush) begin
      cnt <= cnt + 5'd1;
      if (!op_q[2]) {hi, lo} <= {sum, lo[31:1]};
      else begin
        hi <= ge ? sh_low - m : sh_low;
        lo <= {lo[30:0], ge};
      end
    end else if (state == FIX && !flush) result <= fixed;
  end
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  assign stall = rst_n & ((start & (state == IDLE)) | (busy & ~done));
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: directed vectors, random ops against an arithmetic model, flush/reset sequences
module tb_ex_muldiv_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic busy, stall, done;
  logic [31:0] result;
  int total = 0, bad = 0;
  logic [31:0] last_exp = 32'd0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t vecs[$];
  ex_muldiv_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
                     .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint xs, xu, ys, yu, r;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    xu = longint'({32'd0, x});
    yu = longint'({32'd0, y});
    case (o)
      3'd0: r = xs * ys;
      3'd1: begin r = xs * ys; r = r >>> 32; end
      3'd2: begin r = xs * yu; r = r >>> 32; end
      3'd3: begin r = xu * yu; r = r >>> 32; end
      3'd4: r = (y == 0) ? -1 : xs / ys;
      3'd5: r = (y == 0) ? -1 : xu / yu;
      3'd6: r = (y == 0) ? xs : xs % ys;
      default: r = (y == 0) ? xs : xu % yu;
    endcase
    return r[31:0];
  endfunction
  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 0) return 1;
    if (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
    if (o[2] ? (x == 0 && y != 0) : (x == 0 || y == 0)) return 1;
`endif
    return 34;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  task automatic run_op(input bit skip_wait, input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int poke, input logic [31:0] exp_r, input int exp_lat);
    int lat;
    bit busy_ok;
    logic [31:0] r;
    if (!skip_wait) @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    #1 chk({nm, "_stall"}, stall, 1'b1);
    lat = -1;
    busy_ok = 1'b1;
    r = 32'hx;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = (i == poke);
      if (i == poke) begin op = 3'b101; a = ~x; b = 32'd0; end
      else begin op = o; a = x; b = y; end
      if (!busy) busy_ok = 1'b0;
      if (done) begin lat = i; r = result; break; end
    end
    start = 1'b0;
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_res"}, r, exp_r);
    chk({nm, "_busy"}, busy_ok, 1'b1);
    last_exp = exp_r;
  endtask
  initial begin
    bit seen;
    vecs.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 34});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34});
    vecs.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 34});
    vecs.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 34});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'd1, 32'h8000_0000, 34});
    vecs.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd7, 32'd9, 32'd0, 32'd9, 1});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    start = 1'b1;
    #2;
    chk("reset_outs", {busy, done, stall}, 3'b000);
    chk("reset_result", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i])
      run_op(1'b0, $sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].res, vecs[i].lat);
    run_op(1'b0, "busy_start_ignored", 3'd0, 32'd1234, 32'd5678, 5, 32'd7006652, 34);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      logic [31:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      run_op(1'b0, $sformatf("rnd%0d_op%0d", i, o), o, x, y, 0, model(o, x, y), model_lat(o, x, y));
    end
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1'b1;
      if (i == 10) begin flush = 1'b1; start = 1'b1; op = 3'b101; a = 32'd5; b = 32'd0; end
    end
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    if (done) seen = 1'b1;
    chk("flush_idle", busy, 1'b0);
    chk("flush_no_done", seen, 1'b0);
    chk("flush_result_kept", result, last_exp);
    run_op(1'b1, "after_flush", 3'd0, 32'd6, 32'd7, 0, 32'd42, 34);
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'b101; a = 32'd5; b = 32'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_beats_start", busy, 1'b0);
    op = 3'd4; a = 32'd1000; b = 32'd7; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", {busy, done, stall}, 3'b000);
    chk("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("postreset_quiet", seen, 1'b0);
    run_op(1'b0, "mul_zero", 3'd0, 32'd0, 32'd5, 0, 32'd0, model_lat(3'd0, 32'd0, 32'd5));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
